violation_monitor: RTL

- Consumes the registered rule_violation flag from the packet filter stage, one sample per clock.
- Tracks violation bursts inside a sliding-start time window and raises an interrupt when a threshold is crossed.
- Escalates to a traffic lockout if software fails to acknowledge the interrupt in time.
- Sits between the packet filter and the host interrupt/control logic; lockout drives the upstream traffic gate.

---
 rtl/fw_mon_pkg.sv | 29 ++
 rtl/sat_counter.sv | 36 +++
 rtl/violation_monitor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fw_mon_pkg.sv
// ----------------------------------------------------------------------------
// fw_mon_pkg
// Shared definitions for the firewall monitoring stages.
//   - state_e       : 2-bit monitor FSM state, encoding visible on the debug/CSR port
//   - Def*          : default parameter values for violation_monitor
//   - bits_for()    : timer/counter width helper, never narrower than one bit
// ----------------------------------------------------------------------------
package fw_mon_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWatch   = 2'd1,
        StAlert   = 2'd2,
        StLockout = 2'd3
    } state_e;

    localparam int unsigned DefWinLen     = 64;
    localparam int unsigned DefThresh     = 4;
    localparam int unsigned DefAckTimeout = 256;
    localparam int unsigned DefLockHold   = 1024;
    localparam int unsigned DefCntW       = 16;

    // $clog2 of a limit, clamped to at least one bit so a limit of 1 still
    // yields a usable register.
    function automatic int unsigned bits_for(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. A synchronous clear
// takes priority over an increment in the same cycle.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset, zeroes the count
//   clr    in   synchronous clear
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count, WIDTH bits
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/violation_monitor.sv
// ----------------------------------------------------------------------------
// violation_monitor
// Watches the registered rule_violation flag from the packet filter, counts
// violation bursts within a window that opens on the first violation, raises
// an interrupt when THRESH violations land in one window and escalates to a
// traffic lockout if the host does not acknowledge within ACK_TIMEOUT cycles.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-low reset
//   viol_valid      in   qualifies rule_violation this cycle
//   rule_violation  in   violation flag from the filter stage
//   alert_ack       in   host acknowledge pulse (ignored in lockout)
//   clear           in   synchronous soft clear; drops a coincident event
//   alert_irq       out  interrupt to host (ALERT or LOCKOUT), registered
//   lockout         out  upstream traffic gate (LOCKOUT), registered
//   total_count     out  lifetime event count, saturating, CNT_W bits
//   state           out  current FSM state for debug/CSR
//
// Build option:
//   AUTO_UNLOCK_EN  when defined, LOCKOUT releases itself after LOCK_HOLD
//                   cycles; otherwise LOCKOUT holds until clear or reset.
// ----------------------------------------------------------------------------
module violation_monitor
    import fw_mon_pkg::*;
#(
    parameter int unsigned WIN_LEN     = DefWinLen,
    parameter int unsigned THRESH      = DefThresh,
    parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
    parameter int unsigned LOCK_HOLD   = DefLockHold,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             viol_valid,
    input  logic             rule_violation,
    input  logic             alert_ack,
    input  logic             clear,
    output logic             alert_irq,
    output logic             lockout,
    output logic [CNT_W-1:0] total_count,
    output logic [1:0]       state
);

    // Elaboration-time legality checks on the configuration.
    if (WIN_LEN < 2) begin : g_bad_win_len
        $error("violation_monitor: WIN_LEN must be >= 2");
    end
    if (THRESH < 1) begin : g_bad_thresh
        $error("violation_monitor: THRESH must be >= 1");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("violation_monitor: ACK_TIMEOUT must be >= 1");
    end
    if (LOCK_HOLD < 1) begin : g_bad_lock_hold
        $error("violation_monitor: LOCK_HOLD must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("violation_monitor: CNT_W must be >= 1");
    end

    localparam int unsigned WinTW = bits_for(WIN_LEN);
    localparam int unsigned WinCW = bits_for(THRESH + 1);
    localparam int unsigned AckTW = bits_for(ACK_TIMEOUT);

    localparam logic [WinTW-1:0] WinLast  = WinTW'(WIN_LEN - 1);
    localparam logic [WinCW-1:0] ThreshC  = WinCW'(THRESH);
    localparam logic [AckTW-1:0] AckLast  = AckTW'(ACK_TIMEOUT - 1);

`ifdef AUTO_UNLOCK_EN
    localparam int unsigned LockTW = bits_for(LOCK_HOLD);
    localparam logic [LockTW-1:0] LockLast = LockTW'(LOCK_HOLD - 1);
`endif

    logic evt;
    assign evt = viol_valid & rule_violation;

    // ------------------------------------------------------------------------
    // Lifetime event counter. An event coinciding with clear is dropped.
    // ------------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (evt & ~clear),
        .count (total_count)
    );

    // ------------------------------------------------------------------------
    // Monitor FSM with registered output decodes.
    // alert_irq_q / lockout_q are written alongside every state_q update so
    // they always equal the decode of the state being entered.
    // ------------------------------------------------------------------------
    state_e             state_q;
    logic               alert_irq_q;
    logic               lockout_q;
    logic [WinCW-1:0]   win_count_q;
    logic [WinTW-1:0]   win_timer_q;
    logic [AckTW-1:0]   ack_timer_q;
`ifdef AUTO_UNLOCK_EN
    logic [LockTW-1:0]  lock_timer_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            alert_irq_q  <= 1'b0;
            lockout_q    <= 1'b0;
            win_count_q  <= '0;
            win_timer_q  <= '0;
            ack_timer_q  <= '0;
`ifdef AUTO_UNLOCK_EN
            lock_timer_q <= '0;
`endif
        end else if (clear) begin
            state_q      <= StIdle;
            alert_irq_q  <= 1'b0;
            lockout_q    <= 1'b0;
            win_count_q  <= '0;
            win_timer_q  <= '0;
            ack_timer_q  <= '0;
`ifdef AUTO_UNLOCK_EN
            lock_timer_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (evt) begin
                        if (THRESH == 1) begin
                            state_q     <= StAlert;
                            alert_irq_q <= 1'b1;
                            ack_timer_q <= '0;
                        end else begin
                            // First violation opens the window.
                            state_q     <= StWatch;
                            win_count_q <= WinCW'(1);
                            win_timer_q <= WinLast;
                        end
                    end
                end

                StWatch: begin
                    if (evt && ((win_count_q + 1'b1) == ThreshC)) begin
                        // Threshold beats window expiry in the same cycle.
                        state_q     <= StAlert;
                        alert_irq_q <= 1'b1;
                        ack_timer_q <= '0;
                    end else if (win_timer_q == '0) begin
                        if (evt) begin
                            // A violation on the expiry cycle starts a new window.
                            win_count_q <= WinCW'(1);
                            win_timer_q <= WinLast;
                        end else begin
                            state_q     <= StIdle;
                            win_count_q <= '0;
                        end
                    end else begin
                        win_timer_q <= win_timer_q - 1'b1;
                        if (evt) begin
                            win_count_q <= win_count_q + 1'b1;
                        end
                    end
                end

                StAlert: begin
                    // Ack wins over a coincident timeout.
                    if (alert_ack) begin
                        state_q     <= StIdle;
                        alert_irq_q <= 1'b0;
                        win_count_q <= '0;
                    end else if (ack_timer_q == AckLast) begin
                        state_q      <= StLockout;
                        lockout_q    <= 1'b1;
`ifdef AUTO_UNLOCK_EN
                        lock_timer_q <= LockLast;
`endif
                    end else begin
                        ack_timer_q <= ack_timer_q + 1'b1;
                    end
                end

                StLockout: begin
`ifdef AUTO_UNLOCK_EN
                    if (lock_timer_q == '0) begin
                        state_q     <= StIdle;
                        alert_irq_q <= 1'b0;
                        lockout_q   <= 1'b0;
                        win_count_q <= '0;
                    end else begin
                        lock_timer_q <= lock_timer_q - 1'b1;
                    end
`else
                    // Sticky: only clear or reset leaves lockout.
                    state_q <= StLockout;
`endif
                end

                default: begin
                    state_q     <= StIdle;
                    alert_irq_q <= 1'b0;
                    lockout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign alert_irq = alert_irq_q;
    assign lockout   = lockout_q;
    assign state     = state_q;

endmodule
